// File: rtl/calc_pkg.sv
// Shared state encoding and ALU command codes for the calculator input sequencer.
package calc_pkg;

   localparam int unsigned STAGE_W = 3;

   typedef enum logic [STAGE_W-1:0] {
      OP1  = 3'd0,
      OP2  = 3'd1,
      CMD  = 3'd2,
      EXEC = 3'd3,
      SHOW = 3'd4
   } calc_state_t;

   // Command codes understood by ALU_generalizado
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLL = 3'd5;
   localparam logic [2:0] ALU_SRL = 3'd6;
   localparam logic [2:0] ALU_SRA = 3'd7;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a debounced button level: one pulse per press.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic level_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         level_q <= level;
         rise    <= level & ~level_q;
      end
   end

endmodule

// File: rtl/calc_input_sequencer.sv
// Operand/command entry sequencer for the switch-and-button calculator.
// Optional CALC_CHAIN_EN: a press in SHOW feeds the result back as operand A.
module calc_input_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned N_BITS        = 16,
   parameter int unsigned IN_BITS       = 5,
   parameter int unsigned DIGITS_PER_OP = 4,
   parameter int unsigned OP_BITS       = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_BITS-1:0]   val,
   input  logic                 enter_button,
   input  logic                 clear_button,
   input  logic [N_BITS-1:0]    alu_result,
   input  logic                 alu_overflow,
   output logic [N_BITS-1:0]    op1,
   output logic [N_BITS-1:0]    op2,
   output logic [OP_BITS-1:0]   op,
   output logic [N_BITS-1:0]    output_number,
   output logic                 overflow,
   output logic [STAGE_W-1:0]   stage
);

   localparam int unsigned CNT_W = (DIGITS_PER_OP > 1) ? $clog2(DIGITS_PER_OP) : 1;

   calc_state_t          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [N_BITS-1:0]    op1_d, op2_d, num_d;
   logic [OP_BITS-1:0]   op_d;
   logic                 ovf_d;
   logic                 press, clr;
   logic                 last_digit;
   logic [N_BITS-1:0]    digit;

   rise_detect u_enter_rise (.clk(clk), .rst(rst), .level(enter_button), .rise(press));
   rise_detect u_clear_rise (.clk(clk), .rst(rst), .level(clear_button), .rise(clr));

   assign last_digit = (cnt_q == CNT_W'(DIGITS_PER_OP - 1));
   assign digit      = N_BITS'(val);
   assign stage      = STAGE_W'(state_q);

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op1_d   = op1;
      op2_d   = op2;
      op_d    = op;
      ovf_d   = overflow;
      num_d   = output_number;

      // Display trails the entry registers by one cycle
      case (state_q)
         OP1:     num_d = op1;
         OP2:     num_d = op2;
         CMD:     num_d = N_BITS'(op);
         default: num_d = output_number;
      endcase

      if (clr) begin
         state_d = OP1;
         cnt_d   = '0;
         op1_d   = '0;
         op2_d   = '0;
         op_d    = '0;
         ovf_d   = 1'b0;
         num_d   = '0;
      end else begin
         case (state_q)
            OP1: if (press) begin
               op1_d = (op1 << IN_BITS) | digit;
               if (last_digit) begin
                  cnt_d   = '0;
                  state_d = OP2;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            OP2: if (press) begin
               op2_d = (op2 << IN_BITS) | digit;
               if (last_digit) begin
                  cnt_d   = '0;
                  state_d = CMD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            CMD: if (press) begin
               op_d    = val[OP_BITS-1:0];
               state_d = EXEC;
            end
            EXEC: begin
               num_d   = alu_result;
               ovf_d   = alu_overflow;
               state_d = SHOW;
            end
            SHOW: if (press) begin
`ifdef CALC_CHAIN_EN
               op1_d   = output_number;
               state_d = OP2;
`else
               op1_d   = '0;
               state_d = OP1;
`endif
               op2_d = '0;
               op_d  = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end
            default: state_d = OP1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= OP1;
         cnt_q         <= '0;
         op1           <= '0;
         op2           <= '0;
         op            <= '0;
         output_number <= '0;
         overflow      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op1           <= op1_d;
         op2           <= op2_d;
         op            <= op_d;
         output_number <= num_d;
         overflow      <= ovf_d;
      end
   end

endmodule
